vector_group_register_file: RTL
===============================

// Module: vector_group_register_file
// PURPOSE
//  Parametrised vector register file: NUM_VREGS registers of VLEN bits each, with LMUL register-group writes.
//  A write command is accepted, then streams one VLEN-bit beat per destination register.
//  Each element is masked by a v0 snapshot taken at command accept, and by vl. Tail elements are left undisturbed.
//  Sits between decode (three read ports plus v0) and write-back (group write FSM).
// PARAMETERS
//  VLEN          256  bits per vector register
//  NUM_VREGS     32   number of architectural vector registers
//  MAX_LMUL_LOG2 3    largest accepted log2(LMUL); groups of 1..8 registers
//  VL_WIDTH      32   width of the vl input
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  rdy_in      in   1     global enable; 0 freezes the FSM and the read-index latch
//  rs1,rs2,rs3 in   5 ea  read indices, latched on clk while rdy_in=1
//  rs1_data..rs3_data out VLEN  contents of latched index (combinational from array)
//  v0_data     out  VLEN  current v0
//  cmd_valid   in   1     write command valid
//  cmd_ready   out  1     high only in IDLE with rdy_in=1
//  cmd_rd      in   5     group base register
//  cmd_lmul_log2 in 2     group size = 1<<cmd_lmul_log2
//  cmd_sew     in   2     element width: 0=8b, 1=16b, 2=32b, 3=64b
//  cmd_vl      in   VL_WIDTH  active element count across the whole group
//  cmd_vm      in   1     1 = unmasked
//  beat_valid  in   1     write data beat valid
//  beat_ready  out  1     high in WRITE with rdy_in=1
//  beat_data   in   VLEN  data for register cmd_rd+beat_cnt
//  wr_done     out  1     one-cycle pulse after the last beat is written
//  wr_err      out  1     one-cycle pulse on a rejected command
//  rf_status   out  2     0=NOP, 1=BUSY, 2=FINISHED (FINISHED coincides with wr_done)
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - all registers, v0 snapshot and read indices cleared to 0
//   - FSM enters IDLE; wr_done=0, wr_err=0, rf_status=NOP
//  FSM IDLE -> WRITE -> DONE -> IDLE:
//   - IDLE: cmd handshake latches the command fields and snapshots v0, then moves to WRITE with beat_cnt=0.
//     A command is rejected with wr_err for 1 cycle, staying in IDLE, if lmul_log2>MAX_LMUL_LOG2 or cmd_rd is not a multiple of 1<<lmul_log2.
//   - WRITE: each beat handshake writes register rd+beat_cnt at that clock edge and increments beat_cnt.
//     On the last beat (beat_cnt = group size-1) the FSM moves to DONE.
//   - DONE: 1 cycle with wr_done=1 and rf_status=FINISHED; cmd_ready=0; then IDLE.
//  Element rule, per beat b and lane j:
//   - global index e = b*(VLEN/SEW)+j
//   - lane written iff e<vl and (vm or vsnap[e]); otherwise the old bits are kept
//   - bit positions are j*SEW .. j*SEW+SEW-1
//  Boundary cases:
//   - vl=0: all beats are still consumed and no bits change.
//   - vl greater than group capacity: saturates, so the whole group is written.
//   - v0 inside the destination group: the mask stays the snapshot; a new v0 is visible only after its beat is written.
//   - rdy_in=0 mid-group: beat_ready=0, state holds, no writes.
//  Reads: index latched at posedge; data is the array value.
//  rf_status: BUSY in WRITE, NOP otherwise except DONE.
//  Latency: command to wr_done = (1<<lmul_log2)+1 cycles, with back-to-back beats.
// CONFIGURATION
//  VRF_BYPASS_EN defined: a read port whose latched index equals the register being written by the current beat outputs the merged (post-write) value in the same cycle.
//  VRF_BYPASS_EN undefined: that read port outputs the pre-write value; the new value is visible the next cycle.
// STRUCTURE
//  Shared package (vector_defines): SEW encodings, RF_NOP/RF_BUSY/RF_FINISHED, FSM state encodings.
//  Sub-module vrf_lane_merge: combinational old/new/mask/vl -> merged VLEN word, for one beat.
//   - Used by the write path, and by the bypass path when VRF_BYPASS_EN is defined.
// TESTING
//  1. Reset mid-WRITE: lmul_log2=1 command, then rst=0 after beat 0 -> all regs 0, IDLE, cmd_ready=1 after release.
//  2. Masked SEW8 write, cmd_rd=4, vl=5, vm=0, v0=0x15 -> lanes 0,2,4 updated; lanes 1,3,5+ unchanged in v4.
//  3. lmul_log2=2, rd=8, SEW32, vl=20, vm=1 -> v8,v9 full; v10 lanes 0..3; v11 untouched.
//     wr_done rises 5 cycles after the command when beats are back to back.
//  4. Misaligned command rd=3, lmul_log2=1 -> wr_err pulse for 1 cycle, no state change.
//     A command with lmul_log2=3 and MAX_LMUL_LOG2=2 also -> wr_err.
//  5. rdy_in=0 for 3 cycles between beats -> no writes and beat_ready=0 while low; final contents match the unstalled run.
//  6. rs1 latched to v9 during the beat writing v9 -> new value that cycle with VRF_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/vector_defines.sv
// ============================================================================
// Module : vector_defines (package)
// Shared encodings for the vector register file: SEW codes, rf_status codes,
// write-FSM states and the group-size helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vector_defines;

    localparam int BEAT_W = 3;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    localparam logic [1:0] RF_NOP      = 2'd0;
    localparam logic [1:0] RF_BUSY     = 2'd1;
    localparam logic [1:0] RF_FINISHED = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } vrf_state_e;

    function automatic logic [BEAT_W-1:0] last_beat(input logic [1:0] lmul_log2);
        return BEAT_W'((4'd1 << lmul_log2) - 4'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vrf_lane_merge.sv
// ============================================================================
// Module : vrf_lane_merge
// Combinational per-beat merge of old/new register data under v0 mask and vl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vrf_lane_merge
    import vector_defines::*;
#(
    parameter int VLEN     = 256,
    parameter int VL_WIDTH = 32
) (
    input  logic [VLEN-1:0]     old_data_i,
    input  logic [VLEN-1:0]     new_data_i,
    input  logic [VLEN-1:0]     vmask_i,
    input  logic                vm_i,
    input  logic [VL_WIDTH-1:0] vl_i,
    input  logic [1:0]          sew_i,
    input  logic [BEAT_W-1:0]   beat_i,
    output logic [VLEN-1:0]     merged_o
);

    localparam int NBYTES = VLEN / 8;
    localparam int MIDX_W = $clog2(VLEN);

    // Every element is a whole number of bytes, so each byte resolves its
    // owning lane and global element index independently.
    for (genvar k = 0; k < NBYTES; k++) begin : g_byte
        logic [31:0] w_lane;
        logic [31:0] w_elem;
        logic        w_en;

        assign w_lane = 32'(k) >> sew_i;
        assign w_elem = 32'(beat_i) * (32'(NBYTES) >> sew_i) + w_lane;
        assign w_en   = (64'(w_elem) < 64'(vl_i)) &&
                        (vm_i || vmask_i[w_elem[MIDX_W-1:0]]);
        assign merged_o[k*8 +: 8] = w_en ? new_data_i[k*8 +: 8] : old_data_i[k*8 +: 8];
    end

endmodule

`default_nettype wire

// File: rtl/vector_group_register_file.sv
// ============================================================================
// Module : vector_group_register_file
// Vector register file with three latched read ports and an LMUL group write
// FSM. Optional macro VRF_BYPASS_EN forwards the in-flight beat to read ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_group_register_file
    import vector_defines::*;
#(
    parameter int VLEN          = 256,
    parameter int NUM_VREGS     = 32,
    parameter int MAX_LMUL_LOG2 = 3,
    parameter int VL_WIDTH      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy_in,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rs3,
    output logic [VLEN-1:0]     rs1_data,
    output logic [VLEN-1:0]     rs2_data,
    output logic [VLEN-1:0]     rs3_data,
    output logic [VLEN-1:0]     v0_data,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [4:0]          cmd_rd,
    input  logic [1:0]          cmd_lmul_log2,
    input  logic [1:0]          cmd_sew,
    input  logic [VL_WIDTH-1:0] cmd_vl,
    input  logic                cmd_vm,
    input  logic                beat_valid,
    output logic                beat_ready,
    input  logic [VLEN-1:0]     beat_data,
    output logic                wr_done,
    output logic                wr_err,
    output logic [1:0]          rf_status
);

    logic [VLEN-1:0]     vreg_q [NUM_VREGS];
    logic [4:0]          rs1_q, rs2_q, rs3_q;

    vrf_state_e          state_q, state_d;
    logic [4:0]          rd_q, rd_d;
    logic [1:0]          lmul_q, lmul_d;
    logic [1:0]          sew_q, sew_d;
    logic [VL_WIDTH-1:0] vl_q, vl_d;
    logic                vm_q, vm_d;
    logic [VLEN-1:0]     vsnap_q, vsnap_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                err_q, err_d;

    logic                w_cmd_bad;
    logic [4:0]          w_align_mask;
    logic                w_wr_en;
    logic [4:0]          w_wr_idx;
    logic [VLEN-1:0]     w_merged;

    assign w_align_mask = (5'd1 << cmd_lmul_log2) - 5'd1;
    assign w_cmd_bad    = (32'(cmd_lmul_log2) > 32'(MAX_LMUL_LOG2)) ||
                          ((cmd_rd & w_align_mask) != 5'd0);
    assign w_wr_idx     = rd_q + 5'(beat_q);

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        lmul_d     = lmul_q;
        sew_d      = sew_q;
        vl_d       = vl_q;
        vm_d       = vm_q;
        vsnap_d    = vsnap_q;
        beat_d     = beat_q;
        err_d      = 1'b0;
        cmd_ready  = 1'b0;
        beat_ready = 1'b0;
        wr_done    = 1'b0;
        rf_status  = RF_NOP;
        w_wr_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = rdy_in;
                if (cmd_valid && rdy_in) begin
                    if (w_cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d    = cmd_rd;
                        lmul_d  = cmd_lmul_log2;
                        sew_d   = cmd_sew;
                        vl_d    = cmd_vl;
                        vm_d    = cmd_vm;
                        vsnap_d = vreg_q[0];
                        beat_d  = '0;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                beat_ready = rdy_in;
                rf_status  = RF_BUSY;
                if (rdy_in && beat_valid) begin
                    w_wr_en = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == last_beat(lmul_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                wr_done   = 1'b1;
                rf_status = RF_FINISHED;
                if (rdy_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            lmul_q  <= '0;
            sew_q   <= '0;
            vl_q    <= '0;
            vm_q    <= 1'b0;
            vsnap_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            lmul_q  <= lmul_d;
            sew_q   <= sew_d;
            vl_q    <= vl_d;
            vm_q    <= vm_d;
            vsnap_q <= vsnap_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            if (rdy_in) begin
                rs1_q <= rs1;
                rs2_q <= rs2;
                rs3_q <= rs3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                vreg_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            vreg_q[w_wr_idx] <= w_merged;
        end
    end

    vrf_lane_merge #(
        .VLEN     (VLEN),
        .VL_WIDTH (VL_WIDTH)
    ) u_merge (
        .old_data_i (vreg_q[w_wr_idx]),
        .new_data_i (beat_data),
        .vmask_i    (vsnap_q),
        .vm_i       (vm_q),
        .vl_i       (vl_q),
        .sew_i      (sew_q),
        .beat_i     (beat_q),
        .merged_o   (w_merged)
    );

`ifdef VRF_BYPASS_EN
    assign rs1_data = (w_wr_en && (rs1_q == w_wr_idx)) ? w_merged : vreg_q[rs1_q];
    assign rs2_data = (w_wr_en && (rs2_q == w_wr_idx)) ? w_merged : vreg_q[rs2_q];
    assign rs3_data = (w_wr_en && (rs3_q == w_wr_idx)) ? w_merged : vreg_q[rs3_q];
`else
    assign rs1_data = vreg_q[rs1_q];
    assign rs2_data = vreg_q[rs2_q];
    assign rs3_data = vreg_q[rs3_q];
`endif

    assign v0_data = vreg_q[0];
    assign wr_err  = err_q;

endmodule

`default_nettype wire
